// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD modulo counter:
//   bcd_t          4-bit BCD digit type
//   BCD_MAX        largest legal BCD digit (9)
//   BCD_ZERO       zero digit
//   cnt_op_e       per-cycle operation decoded by the counter top level
//   is_valid_bcd   pure check that a digit is in 0..9
//   bcd_value      binary value of a tens/units digit pair (0..165)
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  localparam int BCD_MODULO_MIN = 2;
  localparam int BCD_MODULO_MAX = 100;

  // Operation applied to the digit pair on the next clock edge.
  typedef enum logic [2:0] {
    OP_HOLD,    // keep both digits
    OP_LOAD,    // load the requested digits
    OP_CLEAR,   // force 00 (illegal load, or upward wrap)
    OP_TO_MAX,  // force MODULO-1 (downward wrap)
    OP_INC,     // ripple increment
    OP_DEC      // ripple decrement
  } cnt_op_e;

  function automatic logic is_valid_bcd(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

  // Inputs are 4-bit and may be non-BCD; 15*10+15 = 165 still fits 8 bits.
  function automatic logic [7:0] bcd_value(input bcd_t tens, input bcd_t units);
    return ({4'b0000, tens} * 8'd10) + {4'b0000, units};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One registered BCD digit with clear / load / increment / decrement control.
// Priority: clear_i > load_i > inc_i > dec_i. Increment wraps 9->0 and
// decrement wraps 0->9; the wrap is signalled combinationally on carry_o /
// borrow_o so a neighbouring digit can ripple in the same cycle.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset, digit -> 0
//   clear_i      force digit to 0
//   load_i       load load_val_i
//   load_val_i   digit value to load (caller guarantees it is BCD)
//   inc_i        step up
//   dec_i        step down
//   digit_o      registered digit
//   digit_d_o    value the digit will take on the next edge
//   carry_o      inc_i while the digit is 9
//   borrow_o     dec_i while the digit is 0
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] digit_o,
  output logic [3:0] digit_d_o,
  output logic       carry_o,
  output logic       borrow_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  // NOTE: every combinational output is assigned a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = BCD_ZERO;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : bcd_t'(digit_q + 4'd1);
    end else if (dec_i) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : bcd_t'(digit_q - 4'd1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o   = digit_q;
  assign digit_d_o = digit_d;
  assign carry_o   = inc_i && (digit_q == BCD_MAX);
  assign borrow_o  = dec_i && (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD up/down counter with range 00..MODULO-1 (MODULO in 2..100),
// synchronous validated load, a one-cycle carry/borrow pulse and a registered
// zero flag. All outputs are registered; latency from a request to the
// outputs is one clock.
//
// Configuration macro:
//   BCD_CNT_SAT_EN  when defined, counting saturates at MODULO-1 (up) and at
//                   00 (down) instead of wrapping; carry_o still pulses on
//                   every count attempt made at the boundary.
//
// Parameters:
//   MODULO        count modulus, 2..100 (checked at elaboration)
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset -> 00, zero_o=1, carry_o=0
//   en_i          count one step this cycle
//   up_i          1 = count up, 0 = count down
//   load_i        load strobe, overrides en_i
//   load_units_i  BCD units value to load
//   load_tens_i   BCD tens value to load
//   units_o       BCD units digit
//   tens_o        BCD tens digit
//   carry_o       one-cycle pulse on wrap (or boundary attempt when saturating)
//   zero_o        count is 00
// -----------------------------------------------------------------------------
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int MODULO = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_units_i,
  input  logic [3:0] load_tens_i,
  output logic [3:0] units_o,
  output logic [3:0] tens_o,
  output logic       carry_o,
  output logic       zero_o
);

  if (MODULO < BCD_MODULO_MIN || MODULO > BCD_MODULO_MAX) begin : g_bad_modulo
    $error("bcd_mod_counter: MODULO=%0d outside legal range 2..100", MODULO);
  end

  localparam int         MAX_V     = MODULO - 1;
  localparam bcd_t       MAX_UNITS = bcd_t'(MAX_V % 10);
  localparam bcd_t       MAX_TENS  = bcd_t'(MAX_V / 10);
  localparam logic [7:0] MODULO_W  = 8'(MODULO);

  cnt_op_e op;

  logic carry_d, carry_q;
  logic zero_d, zero_q;

  // Digit control and status.
  logic u_clear, u_load, u_inc, u_dec, u_carry, u_borrow;
  logic t_clear, t_load, t_inc, t_dec, t_carry, t_borrow;
  bcd_t u_load_val, t_load_val;
  bcd_t u_digit, t_digit, u_next, t_next;

  logic load_ok;
  logic at_max;
  logic at_zero;

  // A load is legal only if both digits are BCD and the pair is in range.
  assign load_ok = is_valid_bcd(load_units_i) && is_valid_bcd(load_tens_i) &&
                   (bcd_value(load_tens_i, load_units_i) < MODULO_W);

  assign at_max  = (u_digit == MAX_UNITS) && (t_digit == MAX_TENS);
  assign at_zero = (u_digit == BCD_ZERO)  && (t_digit == BCD_ZERO);

  // Operation decode: load wins over counting; terminal values are caught
  // here so the digits themselves only ever see in-range steps.
  always_comb begin
    op      = OP_HOLD;
    carry_d = 1'b0;
    if (load_i) begin
      op = load_ok ? OP_LOAD : OP_CLEAR;
    end else if (en_i) begin
      if (up_i) begin
        if (at_max) begin
          carry_d = 1'b1;
`ifdef BCD_CNT_SAT_EN
          op = OP_HOLD;
`else
          op = OP_CLEAR;
`endif
        end else begin
          op = OP_INC;
        end
      end else begin
        if (at_zero) begin
          carry_d = 1'b1;
`ifdef BCD_CNT_SAT_EN
          op = OP_HOLD;
`else
          op = OP_TO_MAX;
`endif
        end else begin
          op = OP_DEC;
        end
      end
    end
  end

  // Clear / load controls for both digits.
  always_comb begin
    u_clear    = 1'b0;
    u_load     = 1'b0;
    u_load_val = BCD_ZERO;
    t_clear    = 1'b0;
    t_load     = 1'b0;
    t_load_val = BCD_ZERO;
    case (op)
      OP_LOAD: begin
        u_load     = 1'b1;
        u_load_val = load_units_i;
        t_load     = 1'b1;
        t_load_val = load_tens_i;
      end
      OP_CLEAR: begin
        u_clear = 1'b1;
        t_clear = 1'b1;
      end
      OP_TO_MAX: begin
        u_load     = 1'b1;
        u_load_val = MAX_UNITS;
        t_load     = 1'b1;
        t_load_val = MAX_TENS;
      end
      default: ;
    endcase
  end

  // Step controls kept outside the block above: the tens step depends on the
  // units carry/borrow, which in turn depends on the units step.
  assign u_inc = (op == OP_INC);
  assign u_dec = (op == OP_DEC);
  assign t_inc = u_carry;
  assign t_dec = u_borrow;

  bcd_digit u_units (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (u_clear),
    .load_i     (u_load),
    .load_val_i (u_load_val),
    .inc_i      (u_inc),
    .dec_i      (u_dec),
    .digit_o    (u_digit),
    .digit_d_o  (u_next),
    .carry_o    (u_carry),
    .borrow_o   (u_borrow)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (t_clear),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .inc_i      (t_inc),
    .dec_i      (t_dec),
    .digit_o    (t_digit),
    .digit_d_o  (t_next),
    .carry_o    (t_carry),
    .borrow_o   (t_borrow)
  );

  // The tens digit never rolls over on its own: the MODULO terminal check
  // above always intercepts first, so its carry/borrow are never consumed.
  logic unused_tens_flags;
  assign unused_tens_flags = t_carry | t_borrow;

  // The zero flag is derived from the next digit values so it lands on the
  // same edge as the count it describes.
  assign zero_d = (u_next == BCD_ZERO) && (t_next == BCD_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign units_o = u_digit;
  assign tens_o  = t_digit;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_mod_counter
// Two counters are instantiated: dut_a with MODULO=60 and dut_b with
// MODULO=24. Each stimulus step pushes the expected count/carry for the
// targeted counter onto a scoreboard queue; after the clock edge the entry is
// popped and compared against the sampled outputs. Expected values follow the
// wrap or saturate behaviour selected by BCD_CNT_SAT_EN.
// -----------------------------------------------------------------------------
module tb_bcd_mod_counter;

`ifdef BCD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int MOD_A = 60;
  localparam int MOD_B = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       en_a, up_a, load_a, carry_a, zero_a;
  logic [3:0] lu_a, lt_a, units_a, tens_a;
  logic       en_b, up_b, load_b, carry_b, zero_b;
  logic [3:0] lu_b, lt_b, units_b, tens_b;

  bcd_mod_counter #(.MODULO(MOD_A)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_a),
    .up_i         (up_a),
    .load_i       (load_a),
    .load_units_i (lu_a),
    .load_tens_i  (lt_a),
    .units_o      (units_a),
    .tens_o       (tens_a),
    .carry_o      (carry_a),
    .zero_o       (zero_a)
  );

  bcd_mod_counter #(.MODULO(MOD_B)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_b),
    .up_i         (up_b),
    .load_i       (load_b),
    .load_units_i (lu_b),
    .load_tens_i  (lt_b),
    .units_o      (units_b),
    .tens_o       (tens_b),
    .carry_o      (carry_b),
    .zero_o       (zero_b)
  );

  typedef struct {
    int         dut;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lt;
    logic [3:0] lu;
    int         v;
    logic       c;
    string      nm;
  } stim_t;

  typedef struct {
    int    dut;
    int    v;
    logic  c;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // {tens, units, carry, zero} of the selected counter.
  function automatic logic [9:0] obs(input int d);
    if (d == 0) return {tens_a, units_a, carry_a, zero_a};
    return {tens_b, units_b, carry_b, zero_b};
  endfunction

  function automatic logic [9:0] want(input int v, input logic c);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u, c, (v == 0)};
  endfunction

  function automatic stim_t s_ld(input int d, input int t, input int u, input int v, input string nm);
    stim_t s;
    s = '{d, 1'b0, 1'b0, 1'b1, 4'(t), 4'(u), v, 1'b0, nm};
    return s;
  endfunction

  function automatic stim_t s_cnt(input int d, input logic up, input int v, input logic c, input string nm);
    stim_t s;
    s = '{d, 1'b1, up, 1'b0, 4'd0, 4'd0, v, c, nm};
    return s;
  endfunction

  function automatic stim_t s_hold(input int d, input logic up, input int v, input string nm);
    stim_t s;
    s = '{d, 1'b0, up, 1'b0, 4'd0, 4'd0, v, 1'b0, nm};
    return s;
  endfunction

  function automatic stim_t s_both(input int d, input logic up, input int t, input int u, input int v, input string nm);
    stim_t s;
    s = '{d, 1'b1, up, 1'b1, 4'(t), 4'(u), v, 1'b0, nm};
    return s;
  endfunction

  task automatic idle_inputs();
    en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; lu_a = 4'd0; lt_a = 4'd0;
    en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; lu_b = 4'd0; lt_b = 4'd0;
  endtask

  // Drive one cycle of stimulus on the falling edge, record the expectation,
  // and return just after the sampling rising edge.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    idle_inputs();
    if (s.dut == 0) begin
      en_a = s.en; up_a = s.up; load_a = s.ld; lt_a = s.lt; lu_a = s.lu;
    end else begin
      en_b = s.en; up_b = s.up; load_b = s.ld; lt_b = s.lt; lu_b = s.lu;
    end
    e = '{s.dut, s.v, s.c, s.nm};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      o = obs(d);
      w = want(0, 1'b0);
      if (o !== w) begin
        errors++;
        $display("FAIL reset_initial dut%0d: got %b want %b", d, o, w);
      end
    end
    @(negedge clk);
    #2 reset = 1'b1;

    tbl.push_back(s_ld(0, 3, 6, 36, "reset_pre_load36"));
    tbl.push_back(s_cnt(0, 1'b1, 37, 1'b0, "reset_pre_up37"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end

    // Assert reset between edges while a count is requested.
    @(negedge clk);
    en_a = 1'b1;
    up_a = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    o = obs(0);
    if (o !== want(0, 1'b0)) begin
      errors++;
      $display("FAIL reset_async_mid_count: got %b want %b", o, want(0, 1'b0));
    end
    @(posedge clk);
    #1;
    checks++;
    o = obs(0);
    if (o !== want(0, 1'b0)) begin
      errors++;
      $display("FAIL reset_held_over_edge: got %b want %b", o, want(0, 1'b0));
    end
    // Release with en_i still high: the first edge counts, no carry.
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    o = obs(0);
    if (o !== want(1, 1'b0)) begin
      errors++;
      $display("FAIL reset_release_first_count: got %b want %b", o, want(1, 1'b0));
    end
  endtask

  task automatic test_wrap_up();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    tbl.push_back(s_ld(0, 5, 8, 58, "up_load58"));
    tbl.push_back(s_cnt(0, 1'b1, 59, 1'b0, "up_58_to_59"));
    tbl.push_back(s_cnt(0, 1'b1, SAT ? 59 : 0, 1'b1, "up_wrap_59"));
    tbl.push_back(s_cnt(0, 1'b1, SAT ? 59 : 1, SAT, "up_after_wrap"));
    tbl.push_back(s_hold(0, 1'b1, SAT ? 59 : 1, "up_idle_no_carry"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  task automatic test_wrap_down();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    tbl.push_back(s_ld(1, 0, 0, 0, "dn24_load00"));
    tbl.push_back(s_cnt(1, 1'b0, SAT ? 0 : 23, 1'b1, "dn24_wrap_00"));
    tbl.push_back(s_hold(1, 1'b0, SAT ? 0 : 23, "dn24_idle"));
    tbl.push_back(s_cnt(1, 1'b0, SAT ? 0 : 22, SAT, "dn24_second_pulse"));
    tbl.push_back(s_ld(0, 0, 0, 0, "dn60_load00"));
    tbl.push_back(s_cnt(0, 1'b0, SAT ? 0 : 59, 1'b1, "dn60_wrap_00"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  task automatic test_ripple();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    tbl.push_back(s_ld(0, 0, 8, 8, "rip_load08"));
    tbl.push_back(s_cnt(0, 1'b1, 9, 1'b0, "rip_up_09"));
    tbl.push_back(s_cnt(0, 1'b1, 10, 1'b0, "rip_up_10"));
    tbl.push_back(s_cnt(0, 1'b1, 11, 1'b0, "rip_up_11"));
    tbl.push_back(s_cnt(0, 1'b0, 10, 1'b0, "rip_dn_10"));
    tbl.push_back(s_cnt(0, 1'b0, 9, 1'b0, "rip_dn_09"));
    tbl.push_back(s_ld(0, 4, 0, 40, "rip_load40"));
    tbl.push_back(s_cnt(0, 1'b0, 39, 1'b0, "rip_dn_39"));
    tbl.push_back(s_ld(0, 0, 1, 1, "rip_load01"));
    tbl.push_back(s_cnt(0, 1'b0, 0, 1'b0, "rip_dn_to_00"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  task automatic test_load();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    tbl.push_back(s_ld(0, 1, 1, 11, "ld_11"));
    tbl.push_back(s_ld(0, 7, 5, 0, "ld_75_out_of_range"));
    tbl.push_back(s_ld(0, 1, 1, 11, "ld_11_again"));
    tbl.push_back(s_ld(0, 3, 10, 0, "ld_units_not_bcd"));
    tbl.push_back(s_ld(0, 4, 2, 42, "ld_42"));
    tbl.push_back(s_ld(0, 5, 9, 59, "ld_59_top"));
    tbl.push_back(s_ld(0, 6, 0, 0, "ld_60_eq_modulo"));
    tbl.push_back(s_ld(0, 12, 1, 0, "ld_tens_not_bcd"));
    tbl.push_back(s_ld(1, 2, 3, 23, "ld24_23_top"));
    tbl.push_back(s_ld(1, 2, 4, 0, "ld24_24_eq_modulo"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  task automatic test_priority_hold();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    tbl.push_back(s_ld(0, 1, 0, 10, "pri_load10"));
    tbl.push_back(s_both(0, 1'b1, 3, 3, 33, "pri_load33_with_en"));
    tbl.push_back(s_hold(0, 1'b1, 33, "hold_up"));
    tbl.push_back(s_hold(0, 1'b0, 33, "hold_down"));
    tbl.push_back(s_ld(0, 5, 9, 59, "pri_load59"));
    tbl.push_back(s_both(0, 1'b1, 6, 0, 0, "pri_bad_load_at_max_no_carry"));
    tbl.push_back(s_both(0, 1'b0, 0, 0, 0, "pri_load00_at_zero_no_carry"));
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  // en_i held high across several boundaries; every boundary cycle must carry.
  task automatic test_back_to_back();
    stim_t      tbl[$];
    exp_t       e;
    logic [9:0] o, w;
    int         v;
    logic       c;
    v = 20;
    tbl.push_back(s_ld(1, 2, 0, v, "b2b_load20"));
    for (int k = 0; k < 30; k++) begin
      c = (v == MOD_B - 1);
      v = c ? (SAT ? v : 0) : v + 1;
      tbl.push_back(s_cnt(1, 1'b1, v, c, "b2b_up"));
    end
    for (int k = 0; k < 30; k++) begin
      c = (v == 0);
      v = c ? (SAT ? 0 : MOD_B - 1) : v - 1;
      tbl.push_back(s_cnt(1, 1'b0, v, c, "b2b_down"));
    end
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      o = obs(e.dut);
      w = want(e.v, e.c);
      if (o !== w) begin
        errors++;
        $display("FAIL %s step %0d: got %0d%0d carry=%b zero=%b, want %0d%0d carry=%b zero=%b",
                 e.nm, i, o[9:6], o[5:2], o[1], o[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_ripple();
    test_load();
    test_priority_hold();
    test_back_to_back();
    @(negedge clk);
    idle_inputs();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL have parameter MODULO, default 60, meaning count range 00..MODULO-1 with legal values 2..100.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port en_i, input, 1 bit: count tick, one step per cycle while high.
REQ-005 SHALL have port up_i, input, 1 bit: direction, 1 counts up and 0 counts down.
REQ-006 SHALL have port load_i, input, 1 bit: synchronous load strobe.
REQ-007 SHALL have port load_units_i, input, 4 bits: BCD units value to load.
REQ-008 SHALL have port load_tens_i, input, 4 bits: BCD tens value to load.
REQ-009 SHALL have port units_o, output, 4 bits: registered BCD units digit, feeding the downstream units inverter/decoder.
REQ-010 SHALL have port tens_o, output, 4 bits: registered BCD tens digit.
REQ-011 SHALL have port carry_o, output, 1 bit: one-cycle pulse on wrap or borrow.
REQ-012 SHALL have port zero_o, output, 1 bit: registered flag, high when the count is 00.

Function
REQ-013 SHALL hold value V = 10*tens_o + units_o, always in 0..MODULO-1, with each digit always in 0..9.
REQ-014 SHALL update outputs on the clk edge that samples the request, with latency 1 cycle and no combinational path from inputs to outputs.
REQ-015 SHALL give load_i priority over en_i when both are high in the same cycle; en_i is then ignored for that cycle.
REQ-016 SHALL, on load, accept a value only if both digits are at most 9 and V_load < MODULO; otherwise it SHALL load 00, and carry_o SHALL stay 0.
REQ-017 SHALL, with en_i=1 and up_i=1, step units 0..9; at 9, units go to 0 and tens increment (ripple).
REQ-018 SHALL, with en_i=1 and up_i=1 at V=MODULO-1, go to 00 and pulse carry_o for 1 cycle.
REQ-019 SHALL, with en_i=1 and up_i=0, step units down; at 0, units go to 9 and tens decrement.
REQ-020 SHALL, with en_i=1 and up_i=0 at V=00, go to MODULO-1 and pulse carry_o for 1 cycle.
REQ-021 SHALL hold all state and drive carry_o=0 when en_i=0 and load_i=0.
REQ-022 SHALL pulse carry_o on each qualifying wrap when en_i is held high, with no merging of pulses.
REQ-023 SHALL register zero_o so that it is coincident with the units_o/tens_o value it describes.

Reset
REQ-024 SHALL, while reset=0, force units_o=0, tens_o=0, carry_o=0 and zero_o=1 immediately, independent of clk.
REQ-025 SHALL abandon any in-flight load or count on reset and SHALL NOT emit a carry pulse on reset release.
REQ-026 SHALL honour the first en_i/load_i on the first clk edge after reset deasserts.

Configuration
REQ-027 SHALL recognise the macro BCD_CNT_SAT_EN.
REQ-028 SHALL, when BCD_CNT_SAT_EN is defined, hold the count at MODULO-1 instead of wrapping up, and at 00 instead of wrapping down.
REQ-029 SHALL, when BCD_CNT_SAT_EN is defined, still pulse carry_o for 1 cycle on each count attempt made at the boundary.
REQ-030 SHALL, when BCD_CNT_SAT_EN is undefined, wrap as in REQ-018 and REQ-020.
REQ-031 SHALL implement load and all other behaviour identically with or without BCD_CNT_SAT_EN.

Structure
REQ-032 SHALL take from shared package bcd_pkg the 4-bit BCD digit type, BCD_MAX=9, BCD_ZERO=0 and the pure helper function is_valid_bcd.
REQ-033 SHALL instantiate sub-module bcd_digit twice (units, tens); bcd_digit provides inc/dec/load/clear inputs and carry/borrow-out outputs.
REQ-034 SHALL apply the MODULO terminal detection and the clamp logic at top level, not inside bcd_digit.
REQ-035 SHALL check the MODULO range at elaboration and stop elaboration with an error if it is outside 2..100.

Verification
REQ-036 SHALL cover: reset=0 mid-count at V=37 -> outputs 00, zero_o=1 asynchronously; no carry after release.
REQ-037 SHALL cover: MODULO=60, load 58, en_i=1, up_i=1 for 3 cycles -> 59, 00 with carry_o=1, then 01 with carry_o=0.
REQ-038 SHALL cover: MODULO=24, V=00, up_i=0, en_i pulse -> 23 with carry_o=1; a second pulse -> 22.
REQ-039 SHALL cover: load 7/5 (V=75) with MODULO=60 -> 00; load tens=3, units=10 -> 00; load 4/2 -> 42.
REQ-040 SHALL cover: load_i and en_i high together at V=10, load 3/3 -> 33, with no increment.
REQ-041 SHALL cover: BCD_CNT_SAT_EN defined, MODULO=60, V=59, up_i=1, 2 ticks -> stays 59 with carry_o pulsing each tick; at V=00 with up_i=0 -> stays 00.
